// File: rtl/scdatamem_bytelane_pkg.sv
// Shared definitions for the byte-lane data memory: access size codes,
// clear-engine states and the data-path width.
package scdatamem_bytelane_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/scdatamem_bytelane_if.sv
// Access bus between the datapath (master) and the data memory (slave).
interface scdatamem_bytelane_if #(
  parameter int ADDR_W = 13
);
  import scdatamem_bytelane_pkg::*;

  logic              wena;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              misalign;
  logic              err_sticky;

  modport master (
    output wena, size, sign_ext, addr, data_in,
    input  data_out, busy, misalign, err_sticky
  );

  modport slave (
    input  wena, size, sign_ext, addr, data_in,
    output data_out, busy, misalign, err_sticky
  );

endinterface

// File: rtl/scdatamem_bytelane_lane_align.sv
// Combinational lane logic: alignment decode, store merge into the addressed
// word, and load extraction with sign/zero extension.
module scdatamem_bytelane_lane_align
  import scdatamem_bytelane_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] rd_word,
  output logic              misalign,
  output logic [DATA_W-1:0] wr_word,
  output logic [DATA_W-1:0] rd_data
);

  function automatic logic [DATA_W-1:0] extend_byte(input logic signed [7:0] b,
                                                    input logic sx);
    logic signed [DATA_W-1:0] s;
    s = DATA_W'(b);
    return sx ? s : {24'd0, b};
  endfunction

  function automatic logic [DATA_W-1:0] extend_half(input logic signed [15:0] h,
                                                    input logic sx);
    logic signed [DATA_W-1:0] s;
    s = DATA_W'(h);
    return sx ? s : {16'd0, h};
  endfunction

  logic [3:0]        be;
  logic [DATA_W-1:0] rep;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    rep      = data_in;
    rd_data  = '0;
    byte_sel = rd_word[{off, 3'b000} +: 8];
    half_sel = off[1] ? rd_word[31:16] : rd_word[15:0];

    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << off;
        rep     = {4{data_in[7:0]}};
        rd_data = extend_byte(byte_sel, sign_ext);
      end
      SZ_HALF: begin
        misalign = off[0];
        be       = off[1] ? 4'b1100 : 4'b0011;
        rep      = {2{data_in[15:0]}};
        rd_data  = extend_half(half_sel, sign_ext);
      end
      SZ_WORD: begin
        misalign = (off != 2'b00);
        be       = 4'b1111;
        rd_data  = rd_word;
      end
      default: misalign = 1'b1;
    endcase

    // A misaligned access neither touches memory nor returns data.
    if (misalign) begin
      be      = 4'b0000;
      rd_data = '0;
    end

    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = be[i] ? rep[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/scdatamem_bytelane.sv
// Byte-lane data memory for the single-cycle MIPS datapath with sub-word
// loads/stores, misalignment flagging and a post-reset clear engine.
module scdatamem_bytelane
  import scdatamem_bytelane_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int CLEAR_ON_RESET = 1,
  parameter int READ_REG       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scdatamem_bytelane_if.slave  bus
);

  localparam int                CNT_W = ADDR_W - 2;
  localparam int                DEPTH = 2 ** CNT_W;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              err;
  logic              busy;
  logic              misalign;
  logic [CNT_W-1:0]  widx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_data_p0;

  assign widx    = bus.addr[ADDR_W-1:2];
  assign rd_word = mem[widx];
  assign busy    = (CLEAR_ON_RESET != 0) && (state == ST_CLEAR);

  scdatamem_bytelane_lane_align u_align (
    .size     (bus.size),
    .sign_ext (bus.sign_ext),
    .off      (bus.addr[1:0]),
    .data_in  (bus.data_in),
    .rd_word  (rd_word),
    .misalign (misalign),
    .wr_word  (wr_word),
    .rd_data  (rd_data_p0)
  );

  // Clear engine and sticky error; the counter parks at LAST once READY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == LAST) state <= ST_READY;
          else             cnt   <= cnt + 1'b1;
        end
        default: state <= ST_READY;
      endcase
      if (!busy && bus.wena && misalign) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy)                          mem[cnt]  <= '0;
      else if (bus.wena && !misalign)    mem[widx] <= wr_word;
    end
  end

  // Read stage: either straight through or one registered stage (read-first).
  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [DATA_W-1:0] data_out_p1;
      always_ff @(posedge clk) begin
        if (!rst_n) data_out_p1 <= '0;
        else        data_out_p1 <= busy ? '0 : rd_data_p0;
      end
      assign bus.data_out = data_out_p1;
    end else begin : g_read_comb
      assign bus.data_out = busy ? '0 : rd_data_p0;
    end
  endgenerate

  assign bus.busy       = busy;
  assign bus.misalign   = misalign;
  assign bus.err_sticky = err;

endmodule

// File: tb/tb_scdatamem_bytelane.sv
// Bench for scdatamem_bytelane: combinational-read and registered-read
// instances share stimulus and are checked against an array-based model.
module tb_scdatamem_bytelane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wena;
  logic [1:0]  size;
  logic        sx;
  logic [5:0]  addr;
  logic [31:0] din;
  bit          checking = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  scdatamem_bytelane_if #(.ADDR_W(6)) bus0 ();
  scdatamem_bytelane_if #(.ADDR_W(6)) bus1 ();

  assign bus0.wena = wena;  assign bus0.size = size;  assign bus0.sign_ext = sx;
  assign bus0.addr = addr;  assign bus0.data_in = din;
  assign bus1.wena = wena;  assign bus1.size = size;  assign bus1.sign_ext = sx;
  assign bus1.addr = addr;  assign bus1.data_in = din;

  scdatamem_bytelane #(.ADDR_W(6), .CLEAR_ON_RESET(1), .READ_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  scdatamem_bytelane #(.ADDR_W(6), .CLEAR_ON_RESET(1), .READ_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // Behavioural model: 16 words, remaining-busy count, sticky error, read reg.
  logic [31:0] m_mem [16];
  int          m_busy = 0;
  bit          m_err  = 0;
  logic [31:0] m_dreg = 0;

  function automatic bit m_mis(input logic [1:0] sz, input logic [5:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input bit s, input int off);
    logic [31:0] v;
    case (sz)
      2'd0: begin v = (w >> (8 * off)) & 32'hFF;   if (s && v[7])  v = v | 32'hFFFFFF00; end
      2'd1: begin v = (w >> (8 * off)) & 32'hFFFF; if (s && v[15]) v = v | 32'hFFFF0000; end
      2'd2: v = w;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [1:0] sz,
                                          input int off, input logic [31:0] d);
    logic [31:0] mask, val;
    case (sz)
      2'd0:    begin mask = 32'hFF << (8 * off);   val = (d & 32'hFF) << (8 * off);   end
      2'd1:    begin mask = 32'hFFFF << (8 * off); val = (d & 32'hFFFF) << (8 * off); end
      default: begin mask = 32'hFFFFFFFF;          val = d;                           end
    endcase
    return (old & ~mask) | (val & mask);
  endfunction

  function automatic logic [31:0] m_read();
    if (m_busy > 0 || m_mis(size, addr)) return 32'h0;
    return m_load(m_mem[addr[5:2]], size, sx, int'(addr[1:0]));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 16;
      m_err  = 0;
      m_dreg = 32'h0;
      for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
      m_dreg = 32'h0;
    end else begin
      m_dreg = m_read();
      if (wena) begin
        if (m_mis(size, addr)) m_err = 1;
        else m_mem[addr[5:2]] = m_store(m_mem[addr[5:2]], size, int'(addr[1:0]), din);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("dout_comb",   bus0.data_out,   m_read());
      chk("dout_reg",    bus1.data_out,   m_dreg);
      chk("busy0",       32'(bus0.busy),  32'(m_busy > 0));
      chk("busy1",       32'(bus1.busy),  32'(m_busy > 0));
      chk("misalign",    32'(bus0.misalign), 32'(m_mis(size, addr)));
      chk("err0",        32'(bus0.err_sticky), 32'(m_err));
      chk("err1",        32'(bus1.err_sticky), 32'(m_err));
    end
  end

  task automatic op(input bit w, input logic [1:0] sz, input bit s,
                    input logic [5:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wena = w; size = sz; sx = s; addr = a; din = d;
    @(negedge clk);
  endtask

  task automatic randomize_inputs(input int wena_pct);
    wena = ($urandom_range(99) < wena_pct);
    size = 2'($urandom_range(3));
    sx   = 1'($urandom_range(1));
    addr = 6'($urandom_range(63));
    din  = $urandom;
  endtask

  // Counts busy cycles from the current point, driving random traffic meanwhile.
  task automatic count_busy(output int cnt, input bit traffic);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus0.busy) break;
      cnt++;
      @(posedge clk); #1;
      if (traffic) randomize_inputs(70);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    wena = 0; size = 2'd2; sx = 0; addr = '0; din = '0; rst_n = 0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1; checking = 1;

    count_busy(cnt, 0);
    chk("clear_cycles", 32'(cnt), 32'd16);

    // Word store and sub-word loads
    op(1, 2'd2, 0, 6'h08, 32'h11223344);
    op(0, 2'd0, 1, 6'h09, 32'h0);  chk("lb_09",  bus0.data_out, 32'h00000033);
    op(0, 2'd0, 0, 6'h0B, 32'h0);  chk("lbu_0b", bus0.data_out, 32'h00000011);
    op(0, 2'd1, 0, 6'h0A, 32'h0);  chk("lhu_0a", bus0.data_out, 32'h00001122);
    op(0, 2'd2, 0, 6'h08, 32'h0);  chk("lw_08",  bus0.data_out, 32'h11223344);

    // Byte/half stores keep neighbouring lanes
    op(1, 2'd0, 0, 6'h05, 32'hFFFFFF80);
    op(0, 2'd0, 1, 6'h05, 32'h0);  chk("lb_05",  bus0.data_out, 32'hFFFFFF80);
    op(0, 2'd0, 0, 6'h05, 32'h0);  chk("lbu_05", bus0.data_out, 32'h00000080);
    op(0, 2'd2, 0, 6'h04, 32'h0);  chk("lw_04",  bus0.data_out, 32'h00008000);
    op(1, 2'd0, 0, 6'h0A, 32'h000055AA);
    op(0, 2'd2, 0, 6'h08, 32'h0);  chk("lw_08b", bus0.data_out, 32'h11AA3344);
    op(1, 2'd1, 0, 6'h04, 32'h1234F00D);
    op(0, 2'd1, 1, 6'h04, 32'h0);  chk("lh_04",  bus0.data_out, 32'hFFFFF00D);
    op(0, 2'd2, 0, 6'h04, 32'h0);  chk("lw_04b", bus0.data_out, 32'h0000F00D);

    // Misaligned accesses
    op(1, 2'd1, 0, 6'h03, 32'h0000CAFE);
    chk("sh_03_mis", 32'(bus0.misalign), 32'd1);
    chk("sh_03_err_before", 32'(bus0.err_sticky), 32'd0);
    op(0, 2'd2, 0, 6'h00, 32'h0);
    chk("err_after_sh", 32'(bus0.err_sticky), 32'd1);
    chk("lw_00_kept", bus0.data_out, 32'h00000000);
    op(1, 2'd2, 0, 6'h02, 32'hFFFFFFFF);
    chk("sw_02_mis", 32'(bus0.misalign), 32'd1);
    op(0, 2'd2, 0, 6'h00, 32'h0);  chk("lw_00_kept2", bus0.data_out, 32'h00000000);
    op(0, 2'd2, 0, 6'h02, 32'h0);
    chk("lw_02_data", bus0.data_out, 32'h0);
    chk("lw_02_mis",  32'(bus0.misalign), 32'd1);
    chk("lw_02_err",  32'(bus0.err_sticky), 32'd1);
    op(0, 2'd3, 0, 6'h00, 32'h0);  chk("size11_mis", 32'(bus0.misalign), 32'd1);

    // Registered read is read-first on a same-word store
    op(1, 2'd2, 0, 6'h10, 32'h01020304);
    op(1, 2'd2, 0, 6'h10, 32'hDEADBEEF);
    op(0, 2'd2, 0, 6'h10, 32'h0);  chk("rr_old", bus1.data_out, 32'h01020304);
    op(0, 2'd2, 0, 6'h00, 32'h0);  chk("rr_new", bus1.data_out, 32'hDEADBEEF);

    // Reset mid-clear restarts the sweep; traffic during busy is ignored
    @(posedge clk); #1; rst_n = 0; wena = 0;
    @(posedge clk); #1; rst_n = 1;
    repeat (7) begin
      @(posedge clk); #1; randomize_inputs(80);
    end
    rst_n = 0;
    @(posedge clk); #1; rst_n = 1; randomize_inputs(80);
    count_busy(cnt, 1);
    chk("reclear_cycles", 32'(cnt), 32'd16);
    chk("err_after_clear", 32'(bus0.err_sticky), 32'd0);
    op(0, 2'd2, 0, 6'h10, 32'h0);  chk("lw_10_cleared", bus0.data_out, 32'h0);
    op(0, 2'd2, 0, 6'h08, 32'h0);  chk("lw_08_cleared", bus0.data_out, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1; randomize_inputs(40);
    end
    @(posedge clk); #1; wena = 0;
    @(negedge clk);
    checking = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
